// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, flush/redirect, trap/mret sequencing
// and a watchdog for stalls that never resolve.
module pipe_ctrl #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_wait_i,
    input  logic               id_luse_i,
    input  logic               ex_busy_i,
    input  logic               ls_wait_i,
    input  logic               br_taken_i,
    input  logic [XLEN-1:0]    br_target_i,
    input  logic               trap_req_i,
    input  logic               mret_req_i,
    input  logic [XLEN-1:0]    trap_pc_i,
    input  logic [XLEN-1:0]    trap_cause_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               csr_trap_we_o,
    output logic               csr_mret_o,
    output logic [XLEN-1:0]    csr_epc_o,
    output logic [XLEN-1:0]    csr_cause_o,
    output logic               stall_timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [STALL_W-1:0] ST_LS   = STALL_W'(5'b01111);
    localparam logic [STALL_W-1:0] ST_EX   = STALL_W'(5'b00111);
    localparam logic [STALL_W-1:0] ST_ID   = STALL_W'(5'b00011);
    localparam logic [STALL_W-1:0] ST_IF   = STALL_W'(5'b00001);

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               kind_mret;
    logic [XLEN-1:0]    epc_q;
    logic [XLEN-1:0]    cause_q;
    logic [CW-1:0]      cnt;

    logic [STALL_W-1:0] base;
    logic               capture;
    logic               branch;

    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic               rv_c;
    logic [XLEN-1:0]    rpc_c;
    logic               trap_we_c;
    logic               mret_c;

    always_comb begin
        if (ls_wait_i)      base = ST_LS;
        else if (ex_busy_i) base = ST_EX;
        else if (id_luse_i) base = ST_ID;
        else if (if_wait_i) base = ST_IF;
        else                base = '0;
    end

    // A held LSU does not block capture: the FSM drains it before flushing.
    assign capture = (state == S_IDLE) && (trap_req_i || mret_req_i)
                     && !ex_busy_i;
    assign branch  = (state == S_IDLE) && br_taken_i && !base[2]
                     && !trap_req_i && !mret_req_i;

    always_comb begin
        stall_c   = base;
        flush_c   = 1'b0;
        rv_c      = 1'b0;
        rpc_c     = '0;
        trap_we_c = 1'b0;
        mret_c    = 1'b0;
        state_nx  = state;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    stall_c  = base | ST_EX;
                    state_nx = ls_wait_i ? S_WAIT : S_FLUSH;
                end else if (branch) begin
                    stall_c = '0;
                    flush_c = 1'b1;
                    rv_c    = 1'b1;
                    rpc_c   = br_target_i;
                end
            end
            S_WAIT: begin
                stall_c = base | ST_EX;
                if (!ls_wait_i) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                stall_c   = '0;
                flush_c   = 1'b1;
                rv_c      = 1'b1;
                rpc_c     = kind_mret ? mepc_i : mtvec_i;
                trap_we_c = !kind_mret;
                mret_c    = kind_mret;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign stall_o          = rst ? '0 : stall_c;
    assign flush_o          = !rst && flush_c;
    assign redirect_valid_o = !rst && rv_c;
    assign redirect_pc_o    = rst ? '0 : rpc_c;
    assign csr_trap_we_o    = !rst && trap_we_c;
    assign csr_mret_o       = !rst && mret_c;
    assign csr_epc_o        = rst ? '0 : epc_q;
    assign csr_cause_o      = rst ? '0 : cause_q;
    assign stall_timeout_o  = !rst && (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            kind_mret <= 1'b0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                kind_mret <= !trap_req_i;
                epc_q     <= trap_pc_i;
                cause_q   <= trap_cause_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (stall_o == '0)
            cnt <= '0;
        else if (cnt != CW'(TIMEOUT))
            cnt <= cnt + CW'(1);
    end

endmodule
